// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry skid buffer capturing ALU results with N/Z/OF flags and a saturating overflow count.
// Optional sticky overflow indicator is built only when ALU_STICKY_OF_EN is defined.
module alu_result_stage #(
  parameter int WIDTH   = 6,
  parameter int OFCNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_res,
  input  logic               in_of,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_res,
  output logic               out_n,
  output logic               out_z,
  output logic               out_of,
  output logic [OFCNT_W-1:0] of_count,
  input  logic               sticky_clr,
  output logic               sticky_of
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  localparam int EW = WIDTH + 3;
  state_t             state_q, state_d;
  logic [EW-1:0]      head_q, head_d, tail_q, tail_d, new_ent;
  logic [OFCNT_W-1:0] ofc_q, ofc_d;
  logic               push, pop;
  assign in_ready  = rst_n && state_q != TWO;
  assign out_valid = state_q != EMPTY;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Entry layout {of, z, n, res}: flags are frozen at capture time.
  assign new_ent   = {in_of, in_res == '0, in_res[WIDTH-1], in_res};
  assign {out_of, out_z, out_n, out_res} = head_q;
  assign of_count  = ofc_q;
  always_comb begin
    state_d = (push && !pop) ? (state_q == EMPTY ? ONE : TWO) :
              (pop && !push) ? (state_q == TWO ? ONE : EMPTY) : state_q;
    head_d  = (push && (state_q == EMPTY || (pop && state_q == ONE))) ? new_ent :
              (pop && state_q == TWO) ? tail_q : head_q;
    tail_d  = (push && !pop && state_q == ONE) ? new_ent : tail_q;
    ofc_d   = (push && in_of && ofc_q != '1) ? ofc_q + 1'b1 : ofc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ofc_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ofc_q   <= ofc_d;
    end
  end
`ifdef ALU_STICKY_OF_EN
  logic sticky_q, sticky_d;
  always_comb sticky_d = (push && in_of) ? 1'b1 : sticky_clr ? 1'b0 : sticky_q;
  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= 1'b0;
    else sticky_q <= sticky_d;
  end
  assign sticky_of = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_of = 1'b0;
`endif
endmodule
